// File: rtl/matmul_pkg.sv
// matmul_pkg: FSM states and derived accumulator width shared by the matmul stream engine
package matmul_pkg;
    typedef enum logic [1:0] {IDLE, MAC, EMIT, DONE} state_e;
    function automatic int acc_w(input int data_w, input int m);
        return 2 * data_w + $clog2(m + 1);
    endfunction
endpackage

// File: rtl/matmul_stream_mac_lane.sv
// mac_lane: one K-serial multiply-accumulate lane with selectable signed/unsigned operands
module mac_lane #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 35
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic              signed_mode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc
);
    logic signed [DATA_W:0]     ea;
    logic signed [DATA_W:0]     eb;
    logic signed [2*DATA_W+1:0] prod;
    // One extra operand bit lets a single signed multiplier serve both modes
    assign ea   = {signed_mode & a[DATA_W-1], a};
    assign eb   = {signed_mode & b[DATA_W-1], b};
    assign prod = ea * eb;
    always_ff @(posedge clk)
        if (reset) acc <= '0;
        else if (en) acc <= (clr ? '0 : acc) + ACC_W'(prod);
endmodule

// File: rtl/matmul_stream.sv
// matmul_stream: tiled A x B engine with P MAC lanes and a valid/ready result stream
module matmul_stream
    import matmul_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int N      = 4,
    parameter int M      = 4,
    parameter int Q      = 6,
    parameter int P      = 4,
    localparam int ACC_W = acc_w(DATA_W, M),
    localparam int RW    = N > 1 ? $clog2(N) : 1,
    localparam int CW    = Q > 1 ? $clog2(Q) : 1,
    localparam int KW    = M > 1 ? $clog2(M) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             signed_mode,
    input  logic [N-1:0][M-1:0][DATA_W-1:0]  mat_a,
    input  logic [M-1:0][Q-1:0][DATA_W-1:0]  mat_b,
    output logic                             busy,
    output logic                             done,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic [P-1:0][ACC_W-1:0]          res_data,
    output logic [RW-1:0]                    res_row,
    output logic [CW-1:0]                    res_col,
    output logic [P-1:0]                     res_mask
);
    state_e                  state, state_n;
    logic [RW-1:0]           row, row_n;
    logic [CW-1:0]           col, col_n;
    logic [KW-1:0]           k, k_n;
    logic                    sm, sm_n;
    logic                    last_k, more_cols;
    logic [P-1:0]            mask;
    logic [P-1:0][ACC_W-1:0] acc;

    assign last_k    = k == KW'(M - 1);
    assign more_cols = {1'b0, col} + (CW+1)'(P) < (CW+1)'(Q);

    always_ff @(posedge clk)
        if (reset) begin
            state <= IDLE;
            row   <= '0;
            col   <= '0;
            k     <= '0;
            sm    <= 1'b0;
        end else begin
            state <= state_n;
            row   <= row_n;
            col   <= col_n;
            k     <= k_n;
            sm    <= sm_n;
        end

    always_comb begin
        state_n = state;
        row_n   = row;
        col_n   = col;
        k_n     = k;
        sm_n    = sm;
        case (state)
            IDLE: if (start) begin
                sm_n    = signed_mode;
                row_n   = '0;
                col_n   = '0;
                k_n     = '0;
                state_n = MAC;
            end
            MAC: begin
                k_n     = last_k ? '0 : k + 1'b1;
                state_n = last_k ? EMIT : MAC;
            end
            EMIT: if (res_ready) begin
                col_n   = more_cols ? col + CW'(P) : '0;
                row_n   = more_cols || row == RW'(N - 1) ? row : row + 1'b1;
                state_n = !more_cols && row == RW'(N - 1) ? DONE : MAC;
            end
            default: state_n = IDLE;
        endcase
    end

    // Out-of-range columns feed zero so their accumulators stay at 0
    for (genvar p = 0; p < P; p++) begin : g_lane
        logic [CW:0] cp;
        assign cp      = {1'b0, col} + (CW+1)'(p);
        assign mask[p] = cp < (CW+1)'(Q);
        mac_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_lane (
            .clk         (clk),
            .reset       (reset),
            .clr         (k == '0),
            .en          (state == MAC),
            .signed_mode (sm),
            .a           (mat_a[row][k]),
            .b           (mask[p] ? mat_b[k][cp[CW-1:0]] : '0),
            .acc         (acc[p])
        );
        assign res_data[p] = res_mask[p] ? acc[p] : '0;
    end

    assign busy      = state == MAC || state == EMIT;
    assign done      = state == DONE;
    assign res_valid = state == EMIT;
    assign res_mask  = state == EMIT ? mask : '0;
    assign res_row   = row;
    assign res_col   = col;
endmodule
